// File: rtl/one_cnt_pkg.sv
// Shared types, default parameters and helpers for the windowed detector-hit counter.
package one_cnt_pkg;

   localparam int unsigned DEF_WIN_LEN = 16;
   localparam int unsigned DEF_CNT_W   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Largest value representable in w bits, used as the hit-counter ceiling.
   function automatic logic [31:0] sat_limit(input int unsigned w);
      if (w >= 32) return '1;
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/one_event_window_counter_y_edge_detect.sv
// Registers the detector output and produces the per-cycle hit strobe.
// ONE_CNT_LEVEL_MODE_EN selects level counting (hit = y) instead of rising-edge counting.
module y_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic y,
   output logic hit_c
);

   logic y_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) y_d <= 1'b0;
      else     y_d <= y;
   end

`ifdef ONE_CNT_LEVEL_MODE_EN
   assign hit_c = y;
`else
   assign hit_c = y & ~y_d;
`endif

endmodule

// File: rtl/one_event_window_counter.sv
// Counts detector hits over back-to-back WIN_LEN-cycle windows and publishes each
// window count through a valid/ack handshake with a sticky overflow flag.
// Level-mode counting is selected by ONE_CNT_LEVEL_MODE_EN (see y_edge_detect).
module one_event_window_counter
   import one_cnt_pkg::*;
#(
   parameter int unsigned WIN_LEN = DEF_WIN_LEN,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             y,
   input  logic             cnt_ack,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_valid,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned      WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_limit(CNT_W));

   state_t           state, state_next;
   logic [WIN_W-1:0] win_q, win_n;
   logic [CNT_W-1:0] hits_q, hits_n, hits_inc;
   logic [CNT_W-1:0] cnt_n;
   logic             valid_n, ovf_n, busy_n;
   logic             hit;

   y_edge_detect u_edge (
      .clk   (clk),
      .rst   (rst),
      .y     (y),
      .hit_c (hit)
   );

   // Hit count including this cycle's hit, held at the ceiling instead of wrapping.
   assign hits_inc = (hit && (hits_q != CNT_MAX)) ? hits_q + CNT_W'(1) : hits_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         win_q     <= '0;
         hits_q    <= '0;
         cnt       <= '0;
         cnt_valid <= 1'b0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         win_q     <= win_n;
         hits_q    <= hits_n;
         cnt       <= cnt_n;
         cnt_valid <= valid_n;
         ovf       <= ovf_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_next = state;
      win_n      = win_q;
      hits_n     = hits_q;
      cnt_n      = cnt;
      valid_n    = cnt_valid;
      ovf_n      = ovf;

      if (cnt_ack && cnt_valid) begin
         valid_n = 1'b0;
         ovf_n   = 1'b0;
      end

      case (state)
         IDLE: begin
            win_n  = '0;
            hits_n = '0;
            if (en) state_next = RUN;
         end
         RUN: begin
            if (!en) begin
               // Abort: partial window is dropped without touching the result.
               state_next = IDLE;
               win_n      = '0;
               hits_n     = '0;
            end else if (win_q == WIN_LAST) begin
               // A same-edge ack already cleared ovf above; the new result wins.
               cnt_n   = hits_inc;
               valid_n = 1'b1;
               if (cnt_valid && !cnt_ack) ovf_n = 1'b1;
               win_n   = '0;
               hits_n  = '0;
            end else begin
               win_n  = win_q + WIN_W'(1);
               hits_n = hits_inc;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_n = (state_next == RUN);
   end

endmodule

// File: tb/tb_one_event_window_counter.sv
// Directed bench for one_event_window_counter with WIN_LEN=8 (CNT_W=4 plus a CNT_W=2 copy).
module tb_one_event_window_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       y;
   logic       cnt_ack;
   logic [3:0] cnt;
   logic       cnt_valid, ovf, busy;
   logic [1:0] cnt2;
   logic       cnt_valid2, ovf2, busy2;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   one_event_window_counter #(.WIN_LEN(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .y(y), .cnt_ack(cnt_ack),
      .cnt(cnt), .cnt_valid(cnt_valid), .ovf(ovf), .busy(busy)
   );

   one_event_window_counter #(.WIN_LEN(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .y(y), .cnt_ack(cnt_ack),
      .cnt(cnt2), .cnt_valid(cnt_valid2), .ovf(ovf2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one full window (cycle i uses pat[i] / ack[i]); returns just after the window-end edge.
   task automatic run_window(input logic [7:0] pat, input logic [7:0] ack);
      for (int i = 0; i < 8; i++) begin
         y       = pat[i];
         cnt_ack = ack[i];
         tick();
         if (i == 0 && ack[0]) begin
            check("ack_clears_valid", 32'(cnt_valid), 32'd0);
            check("ack_clears_ovf", 32'(ovf), 32'd0);
         end
      end
      cnt_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; y = 1'b0; cnt_ack = 1'b0;
      tick(); tick();
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_valid", 32'(cnt_valid), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // Enter RUN: busy rises one cycle after en.
      en = 1'b1;
      check("busy_before_edge", 32'(busy), 32'd0);
      tick();
      check("busy_after_en", 32'(busy), 32'd1);

      // Single long pulse on cycles 2..4.
      run_window(8'b0001_1100, 8'h00);
`ifdef ONE_CNT_LEVEL_MODE_EN
      check("pulse_cnt", 32'(cnt), 32'd3);
`else
      check("pulse_cnt", 32'(cnt), 32'd1);
`endif
      check("pulse_valid", 32'(cnt_valid), 32'd1);
      check("pulse_ovf", 32'(ovf), 32'd0);

      // Alternating input, acked in cycle 0; the 2-bit copy saturates.
      run_window(8'b1010_1010, 8'h01);
      check("alt_cnt", 32'(cnt), 32'd4);
      check("alt_valid", 32'(cnt_valid), 32'd1);
      check("sat_cnt", 32'(cnt2), 32'd3);
      check("alt_ovf", 32'(ovf), 32'd0);

      // Two unacked windows with 2 then 3 hits.
      run_window(8'b0000_1010, 8'h00);
      check("ovf_win1_cnt", 32'(cnt), 32'd2);
      check("ovf_win1_ovf", 32'(ovf), 32'd1);
      run_window(8'b0010_1010, 8'h00);
      check("ovf_win2_cnt", 32'(cnt), 32'd3);
      check("ovf_win2_ovf", 32'(ovf), 32'd1);
      check("ovf_win2_valid", 32'(cnt_valid), 32'd1);

      // Ack in cycle 0 clears both flags; window result re-raises valid only.
      run_window(8'b0000_0001, 8'h01);
      check("post_ack_cnt", 32'(cnt), 32'd1);
      check("post_ack_valid", 32'(cnt_valid), 32'd1);
      check("post_ack_ovf", 32'(ovf), 32'd0);

      // Unacked result overwritten -> ovf; then ack coincident with window end.
      run_window(8'b0000_0101, 8'h00);
      check("ovf_again", 32'(ovf), 32'd1);
      run_window(8'b0001_0101, 8'h80);
      check("ack_at_end_cnt", 32'(cnt), 32'd3);
      check("ack_at_end_valid", 32'(cnt_valid), 32'd1);
      check("ack_at_end_ovf", 32'(ovf), 32'd0);

      // Abort at window cycle 5: no report, previous result kept.
      for (int i = 0; i < 5; i++) begin
         y = i[0];
         tick();
      end
      en = 1'b0;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cnt", 32'(cnt), 32'd3);
      check("abort_valid", 32'(cnt_valid), 32'd1);
      repeat (4) tick();
      check("abort_cnt_held", 32'(cnt), 32'd3);
      check("abort_ovf_held", 32'(ovf), 32'd0);

      // Reset in window cycle 4 clears outputs before the next edge.
      y = 1'b0;
      en = 1'b1;
      tick();
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check("midrst_cnt", 32'(cnt), 32'd0);
      check("midrst_valid", 32'(cnt_valid), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      check("rst_release_idle", 32'(busy), 32'd0);
      tick();
      check("restart_busy", 32'(busy), 32'd1);
      run_window(8'b1010_1010, 8'h00);
      check("restart_cnt", 32'(cnt), 32'd4);
      check("restart_valid", 32'(cnt_valid), 32'd1);
      check("restart_ovf", 32'(ovf), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/one_event_window_counter.md
# one_event_window_counter

Downstream consumer of the "more than one 1" sequence detector output `y`. Counts detector hits (rising edges of `y`) over consecutive fixed-length windows of `WIN_LEN` clock cycles. Publishes each window's count through a valid/ack handshake, with a sticky overflow flag for unacknowledged results. Sits between the detector FSM and the status/register logic that reads event rates.

## Interface
- `WIN_LEN`, default 16: window length in clock cycles; legal range is ≥2.
- `CNT_W`, default 8: width of the hit counter and of `cnt`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enables windowed counting.
- `y`  in  1  detector output (registered upstream).
- `cnt_ack`  in  1  consumer acknowledges `cnt`.
- `cnt`  out  CNT_W  count of the last completed window.
- `cnt_valid`  out  1  `cnt` holds an unacknowledged result.
- `ovf`  out  1  sticky flag: a result was overwritten before it was acknowledged.
- `busy`  out  1  high while the state is RUN.

## Operation
- **Reset.** While `rst` is high, asynchronously: state=IDLE; `cnt`=0; `cnt_valid`=0; `ovf`=0; `busy`=0; window counter=0; hit counter=0; `y_d`=0.
- **Edge detect.** `y_d` registers `y` every cycle in both states. `hit = y & ~y_d`.
- **IDLE.**
  - Window and hit counters are held at 0.
  - `en`=1 → RUN at the next edge. The first RUN cycle is window cycle 0.
- **RUN, `en`=1 at the edge.**
  - The window counter increments.
  - On `hit`, the hit counter increments, saturating at 2^CNT_W−1 with no wrap.
- **RUN, window end.** Window counter == WIN_LEN−1 with `en`=1 at the edge:
  - `cnt` loads the final count, including a hit in that cycle.
  - `cnt_valid` is set.
  - Both counters restart at 0, so windows run back-to-back with no gap cycle.
- **RUN, `en`=0 at the edge.**
  - That cycle is not counted.
  - State → IDLE and the partial window is discarded: no report, and `cnt`, `cnt_valid` and `ovf` are unchanged.
- **Handshake.**
  - `cnt_ack`=1 with `cnt_valid`=1 clears `cnt_valid` and `ovf` at the next edge.
  - `cnt_ack` is ignored while `cnt_valid`=0.
- **Simultaneous ack and window end.** The new result wins: `cnt` updates, `cnt_valid` stays 1, and `ovf` is cleared.
- **Window end with `cnt_valid`=1 and no ack.** `cnt` is overwritten with the new count and `ovf` is set. `ovf` stays 1 until acknowledged.
- **`busy`** = (state == RUN).

## Timing
- A hit on the edge that samples `y` rising is counted at that same edge.
- The window-end edge updates `cnt` and raises `cnt_valid`; both are visible the cycle after the last window cycle.
- Ack to `cnt_valid` low: 1 cycle.
- `en` rise to `busy` high: 1 cycle. `en` fall in RUN to `busy` low: 1 cycle.
- `rst` asserted mid-window clears all outputs immediately (asynchronously), without waiting for a clock edge.

## Configuration
- `ONE_CNT_LEVEL_MODE_EN` defined: `hit = y`, so every RUN cycle with `y`=1 is counted (high-time measurement). `y_d` is still present but unused.
- `ONE_CNT_LEVEL_MODE_EN` undefined: rising-edge counting as described above.

## Structure
- Shared package `one_cnt_pkg` holds:
  - the state typedef (IDLE, RUN);
  - default `WIN_LEN`/`CNT_W` constants;
  - the saturation-limit helper.
- Sub-module `y_edge_detect`: the `y_d` register and `hit` generation. The level/edge macro is confined there.
- The top level holds the FSM, the counters and the handshake registers.

## Test plan
All scenarios use WIN_LEN=8, CNT_W=4 unless stated otherwise.
- **Reset mid-window.** `rst` pulsed during RUN window cycle 4 → `cnt`, `cnt_valid`, `ovf`, `busy` are 0 before the next edge; after release, counting restarts only from IDLE.
- **Single long pulse.** `y` high for window cycles 2–4 only → `cnt`=1, `cnt_valid`=1 one cycle after window cycle 7.
- **Alternating input.** `y` = 0,1,0,1,0,1,0,1 over one window → `cnt`=4. With `ONE_CNT_LEVEL_MODE_EN` and `y` held 1 for all 8 cycles → `cnt`=8.
- **Saturation.** CNT_W=2, same alternating pattern → `cnt`=3 (saturated, not 0).
- **Overflow.** No ack across two windows with 2 then 3 hits → `cnt`=3, `ovf`=1. Then `cnt_ack`=1 for one cycle → `cnt_valid`=0 and `ovf`=0 next cycle. Ack coincident with a window end → `cnt_valid` stays 1 and `ovf`=0.
- **Abort.** `en` dropped at window cycle 5 → no `cnt_valid` rise, `busy`=0 next cycle, previous `cnt` unchanged.
